// File: rtl/t03_sprite_streamer.sv
// t03_sprite_streamer
// Pixel-serial sprite fetch engine. A request latches one player's pose,
// facing and visibility, walks the sprite in row-major screen order reading
// an external synchronous ROM (mirrored source column when required), and
// streams the pixels out through a 2-entry skid FIFO with a valid/ready
// handshake. Blank sprites run through the same pipeline slots with no ROM
// reads so that pixel count, ordering and timing are identical.
module t03_sprite_streamer #(
  parameter int SPRITE_W = 15,
  parameter int SPRITE_H = 20,
  parameter int PIX_W = 8,
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_POSES = 3,
  parameter logic [NUM_PLAYERS-1:0] BASE_FLIP = 2'b01,
  parameter logic [PIX_W-1:0] TRANSPARENT = 8'h00,
  parameter int ADDR_W = $clog2(NUM_POSES * SPRITE_H * SPRITE_W),
  localparam int PLW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int XW = $clog2(SPRITE_W),
  localparam int YW = $clog2(SPRITE_H)
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [2*NUM_PLAYERS-1:0] player_state,
  input  logic [NUM_PLAYERS-1:0]   facing_left,
  input  logic [NUM_PLAYERS-1:0]   displayed,
  input  logic                     req_valid,
  input  logic [PLW-1:0]           req_player,
  output logic                     req_ready,
  output logic                     rom_en,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [PIX_W-1:0]         rom_data,
  output logic                     pixel_valid,
  input  logic                     pixel_ready,
  output logic [PIX_W-1:0]         pixel_data,
  output logic [XW-1:0]            pixel_x,
  output logic [YW-1:0]            pixel_y,
  output logic                     pixel_opaque,
  output logic                     pixel_last,
  output logic                     done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [XW-1:0] COL_LAST = XW'(SPRITE_W - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(SPRITE_H - 1);
  localparam logic [ADDR_W-1:0] POSE_STRIDE = ADDR_W'(SPRITE_H * SPRITE_W);
  localparam logic [ADDR_W-1:0] ROW_STRIDE  = ADDR_W'(SPRITE_W);

  // FIFO entry layout: {data, x, y, last, opaque}
  localparam int EW = PIX_W + XW + YW + 2;

  // Request context, latched at acceptance only
  logic [1:0]    state_reg;
  logic [1:0]    pose_reg;
  logic          mirror_reg;
  logic          blank_reg;

  // Read walk counters in screen order
  logic [XW-1:0] col_reg;
  logic [YW-1:0] row_reg;

  // The one read slot currently waiting for ROM data
  logic          inflight_reg;
  logic [XW-1:0] fl_x_reg;
  logic [YW-1:0] fl_y_reg;
  logic          fl_last_reg;

  // Output FIFO bookkeeping
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    count_reg;
  logic [1:0]    count_next;

  logic          done_reg;

  // Acceptance-time decode of the requesting player
  logic [1:0]    acc_pose;
  logic          acc_mirror;
  logic          acc_blank;
  logic          player_oor;

  // Pipeline control
  logic          pop;
  logic          push;
  logic [2:0]    load;
  logic          issue;
  logic [XW-1:0] src_col;
  logic [PIX_W-1:0] push_data;
  logic          push_opaque;
  logic [EW-1:0] push_ent;
  logic [EW-1:0] ent_q [2];
  logic [EW-1:0] head;
  logic [PIX_W-1:0] head_data;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic          head_last;
  logic          head_opaque;

  // A player index can only be out of range when the index field has spare codes
  generate
    if ((1 << PLW) > NUM_PLAYERS) begin : g_oor
      assign player_oor = (int'(req_player) >= NUM_PLAYERS);
    end else begin : g_no_oor
      assign player_oor = 1'b0;
    end
  endgenerate

  // Decode pose, mirror and blank for the player currently presented on the request port
  always_comb begin
    acc_pose   = player_state[{req_player, 1'b0} +: 2];
    acc_mirror = facing_left[req_player] ^ BASE_FLIP[req_player];
    acc_blank  = !displayed[req_player] || (int'(acc_pose) >= NUM_POSES) || player_oor;
  end

  // Read issue: keep buffered plus in-flight pixels at most 2 after this cycle's pop
  always_comb begin
    pop   = pixel_valid && pixel_ready;
    push  = inflight_reg;
    load  = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    issue = (state_reg == FETCH) && (load < 3'd2);
    count_next = count_reg + {1'b0, push} - {1'b0, pop};
  end

  // ROM address generation; the screen column is mirrored into the source column
  always_comb begin
    src_col  = mirror_reg ? (COL_LAST - col_reg) : col_reg;
    rom_addr = ADDR_W'(pose_reg) * POSE_STRIDE
             + ADDR_W'(row_reg) * ROW_STRIDE
             + ADDR_W'(src_col);
    rom_en   = issue && !blank_reg;
  end

  // Returning pixel: blank sprites substitute zero so the slot still carries a pixel
  always_comb begin
    push_data   = blank_reg ? '0 : rom_data;
    push_opaque = !blank_reg && (rom_data != TRANSPARENT);
    push_ent    = {push_data, fl_x_reg, fl_y_reg, fl_last_reg, push_opaque};
  end

  // Control FSM: accept a request, fetch every pixel slot, then wait for the FIFO to empty
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg  <= IDLE;
      pose_reg   <= 2'd0;
      mirror_reg <= 1'b0;
      blank_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            pose_reg   <= acc_pose;
            mirror_reg <= acc_mirror;
            blank_reg  <= acc_blank;
            state_reg  <= FETCH;
          end
        end
        FETCH: begin
          if (issue && (col_reg == COL_LAST) && (row_reg == ROW_LAST)) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (done_reg) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Row/column walk: restarts on acceptance, advances once per issued slot
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if ((state_reg == IDLE) && req_valid) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (issue) begin
      if (col_reg == COL_LAST) begin
        col_reg <= '0;
        if (row_reg != ROW_LAST) begin
          row_reg <= row_reg + YW'(1);
        end
      end else begin
        col_reg <= col_reg + XW'(1);
      end
    end
  end

  // Track the slot whose ROM data arrives next cycle, along with its screen coordinates
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      inflight_reg <= 1'b0;
      fl_x_reg     <= '0;
      fl_y_reg     <= '0;
      fl_last_reg  <= 1'b0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        fl_x_reg    <= col_reg;
        fl_y_reg    <= row_reg;
        fl_last_reg <= (col_reg == COL_LAST) && (row_reg == ROW_LAST);
      end
    end
  end

  // Done pulses once when the final pixel has been handed off and nothing remains
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= (state_reg == DRAIN) && !done_reg && !inflight_reg && (count_next == 2'd0);
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

  // Two FIFO slots, each written only when the write pointer selects it
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [EW-1:0] entry_reg;
      // Capture the returning pixel into this slot
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= push_ent;
        end
      end
      assign ent_q[gi] = entry_reg;
    end
  endgenerate

  assign head = ent_q[rd_ptr_reg];
  assign {head_data, head_x, head_y, head_last, head_opaque} = head;

  // Output port drive; fields are zero whenever no pixel is offered
  always_comb begin
    req_ready    = (state_reg == IDLE);
    pixel_valid  = (count_reg != 2'd0);
    pixel_data   = pixel_valid ? head_data : '0;
    pixel_x      = pixel_valid ? head_x : '0;
    pixel_y      = pixel_valid ? head_y : '0;
    pixel_last   = pixel_valid && head_last;
    pixel_opaque = pixel_valid && head_opaque;
    done         = done_reg;
  end

endmodule
